rc5_round_ctrl: RTL and testbench

RC5_ROUND_CTRL -- requirements
Module: rc5_round_ctrl

---
 rtl/rc5_pkg.sv | 25 ++
 rtl/rc5_addr_gen.sv | 46 ++++
 rtl/rc5_round_ctrl.sv | 141 ++++++++++++++
 tb/tb_rc5_round_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc5_pkg.sv
// rc5_pkg: shared definitions for the RC5 round controller slice.
// Holds the default cipher word width and round count, the key-table size
// formula, and the FSM state and cipher-mode enumerations.
package rc5_pkg;

  localparam int RC5_W_DEF = 32;
  localparam int RC5_R_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rc5_state_e;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } rc5_mode_e;

  // Expanded key table holds 2R+2 words: two whitening words plus two per round.
  function automatic int rc5_t_entries(input int r);
    return 2 * r + 2;
  endfunction

endpackage

// File: rtl/rc5_addr_gen.sv
// rc5_addr_gen: even key-table index counter for the RC5 round controller.
// On load it presents the first index of the sweep (0 going up, AMAX going
// down) in the same cycle; each step presents the next even index. The last
// flag marks the final index of the sweep in the chosen direction.
module rc5_addr_gen
  import rc5_pkg::*;
#(
  parameter int TL   = 5,
  parameter int AMAX = 24
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          dir,
  output logic [TL-1:0] addr,
  output logic          last
);

  localparam logic [TL-1:0] TOP = TL'(AMAX);
  localparam logic [TL-1:0] TWO = TL'(2);

  logic [TL-1:0] cnt_q;
  logic [TL-1:0] base;

  // Current index: the sweep start on load, otherwise the running count.
  always_comb begin
    base = cnt_q;
    if (load) begin
      base = dir ? TOP : '0;
    end
  end

  assign addr = base;
  assign last = dir ? (base == '0) : (base == TOP);

  // Advance two entries per issued address, up for encrypt and down for decrypt.
  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load || step) begin
      cnt_q <= dir ? (base - TWO) : (base + TWO);
    end
  end

endmodule

// File: rtl/rc5_round_ctrl.sv
// rc5_round_ctrl: sequences one RC5 block through the key-table reads and
// datapath operations (load, whitening, R rounds), then holds the result
// until the consumer takes it. Only one block is in flight at a time.
// Build option: define RC5_DECRYPT_EN to add the in_mode port and the
// reversed (decrypt) key order; without it the controller is encrypt-only.
module rc5_round_ctrl
  import rc5_pkg::*;
#(
  parameter int R = RC5_R_DEF,
  parameter int W = RC5_W_DEF
) (
  input  logic                                  clk1,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
`ifdef RC5_DECRYPT_EN
  input  logic                                  in_mode,
`endif
  output logic                                  s_rd_en,
  output logic [$clog2(rc5_t_entries(R))-1:0]   S_address,
  output logic                                  dp_load,
  output logic                                  dp_white,
  output logic                                  dp_step,
  output logic                                  dp_mode,
  output logic [$clog2(R+1)-1:0]                round_idx,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int T  = rc5_t_entries(R);
  localparam int TL = $clog2(T);
  localparam int RW = $clog2(R + 1);

  if (R < 1 || R > 255 || W < 1) begin : g_bad_param
    $error("rc5_round_ctrl: R must be 1..255 and W must be positive");
  end

  rc5_state_e    state_q, state_d;
  rc5_mode_e     mode_q;
  logic          mode_in;
  logic          fire;
  logic          dir;
  logic          vld_p0;
  logic          iss_q;
  logic [TL-1:0] addr;
  logic          last;
  logic          vld_p1;
  logic          last_p1;
  logic [RW-1:0] half_p1;
  logic          is_white;
  logic          is_step;

`ifdef RC5_DECRYPT_EN
  assign mode_in = in_mode;
`else
  assign mode_in = 1'b0;
`endif

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign fire     = in_valid && in_ready;
  assign dir      = fire ? mode_in : (mode_q == MODE_DEC);

  // ---- stage p0: key-table address issue (accept cycle through cycle R) ----
  assign vld_p0 = fire || ((state_q == ST_RUN) && iss_q && !rst);

  rc5_addr_gen #(
    .TL   (TL),
    .AMAX (2 * R)
  ) u_addr_gen (
    .clk1 (clk1),
    .rst  (rst),
    .load (fire),
    .step (vld_p0 && !fire),
    .dir  (dir),
    .addr (addr),
    .last (last)
  );

  assign s_rd_en   = vld_p0;
  assign S_address = vld_p0 ? addr : '0;
  assign dp_load   = fire;

  // Control state: issue window, op-stage valid/last, and the latched mode.
  always_ff @(posedge clk1) begin
    if (rst) begin
      iss_q   <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      mode_q  <= MODE_ENC;
    end else begin
      iss_q   <= vld_p0 && !last;
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && last;
      if (fire) begin
        mode_q <= rc5_mode_e'(mode_in);
      end
    end
  end

  // ---- stage p1: datapath op using the S pair read one cycle earlier ----
  // Index a/2 of the pair names the op in both directions: 0 is whitening,
  // anything else is the round of that number.
  always_ff @(posedge clk1) begin
    half_p1 <= RW'(addr[TL-1:1]);
  end

  assign is_white  = vld_p1 && (half_p1 == '0) && !rst;
  assign is_step   = vld_p1 && (half_p1 != '0) && !rst;
  assign dp_white  = is_white;
  assign dp_step   = is_step;
  assign round_idx = is_step ? half_p1 : '0;

`ifdef RC5_DECRYPT_EN
  assign dp_mode = (mode_q == MODE_DEC) && !rst;
`else
  assign dp_mode = 1'b0;
`endif

  assign out_valid = (state_q == ST_DONE) && !rst;

  // FSM state register.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: run until the last op has been applied, then hold the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fire)      state_d = ST_RUN;
      ST_RUN:  if (last_p1)   state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc5_round_ctrl.sv
// tb_rc5_round_ctrl: self-checking bench for rc5_round_ctrl. Two instances
// (R=12 and R=1) share the same stimulus; each is compared every cycle
// against a timeline model that derives the expected outputs from the
// offset since the block was accepted.
`timescale 1ns/1ps
module tb_rc5_round_ctrl;

  localparam int RA  = 12;
  localparam int RB  = 1;
  localparam int TLA = $clog2(2 * RA + 2);
  localparam int TLB = $clog2(2 * RB + 2);
  localparam int RWA = $clog2(RA + 1);
  localparam int RWB = $clog2(RB + 1);
`ifdef RC5_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  typedef struct packed {
    int in_ready;
    int s_rd_en;
    int addr;
    int dp_load;
    int dp_white;
    int dp_step;
    int ridx;
    int out_valid;
    int dp_mode;
    bit mode_ck;
  } exp_t;

  logic clk1 = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_mode = 1'b0;
  logic out_ready = 1'b1;

  logic a_in_ready, a_s_rd_en, a_dp_load, a_dp_white, a_dp_step, a_dp_mode, a_out_valid;
  logic [TLA-1:0] a_addr;
  logic [RWA-1:0] a_ridx;
  logic b_in_ready, b_s_rd_en, b_dp_load, b_dp_white, b_dp_step, b_dp_mode, b_out_valid;
  logic [TLB-1:0] b_addr;
  logic [RWB-1:0] b_ridx;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit busy [2];
  int off [2];
  bit mode [2];
  int rv [2];
  int lat_acc [2];
  bit ov_prev [2];
  int ov_cnt [2];
  bit gap_ck = 1'b0;
  int last_acc = -1;

  always #5 clk1 = ~clk1;

  rc5_round_ctrl #(.R(RA)) dut_a (
    .clk1      (clk1),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
`ifdef RC5_DECRYPT_EN
    .in_mode   (in_mode),
`endif
    .s_rd_en   (a_s_rd_en),
    .S_address (a_addr),
    .dp_load   (a_dp_load),
    .dp_white  (a_dp_white),
    .dp_step   (a_dp_step),
    .dp_mode   (a_dp_mode),
    .round_idx (a_ridx),
    .out_valid (a_out_valid),
    .out_ready (out_ready)
  );

  rc5_round_ctrl #(.R(RB)) dut_b (
    .clk1      (clk1),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
`ifdef RC5_DECRYPT_EN
    .in_mode   (in_mode),
`endif
    .s_rd_en   (b_s_rd_en),
    .S_address (b_addr),
    .dp_load   (b_dp_load),
    .dp_white  (b_dp_white),
    .dp_step   (b_dp_step),
    .dp_mode   (b_dp_mode),
    .round_idx (b_ridx),
    .out_valid (b_out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit cur_mode();
    return DEC_EN && in_mode;
  endfunction

  // Expected outputs this cycle from the block timeline (offset since accept).
  function automatic exp_t model_out(input int i);
    exp_t e;
    int r;
    int k;
    int j;
    e = '0;
    r = rv[i];
    e.mode_ck = 1'b1;
    if (rst) return e;
    if (!busy[i]) begin
      e.mode_ck = 1'b0;
      e.in_ready = 1;
      if (in_valid) begin
        e.dp_load = 1;
        e.s_rd_en = 1;
        e.addr = cur_mode() ? 2 * r : 0;
      end
      return e;
    end
    k = off[i];
    e.dp_mode = int'(mode[i]);
    if (k <= r) begin
      e.s_rd_en = 1;
      e.addr = mode[i] ? (2 * r - 2 * k) : (2 * k);
    end
    if (k >= 1 && k <= r + 1) begin
      j = k - 1;
      if ((!mode[i] && j == 0) || (mode[i] && j == r)) begin
        e.dp_white = 1;
      end else begin
        e.dp_step = 1;
        e.ridx = mode[i] ? (r - j) : j;
      end
    end
    if (k >= r + 2) e.out_valid = 1;
    return e;
  endfunction

  function automatic exp_t obs(input int i);
    exp_t o;
    o = '0;
    if (i == 0) begin
      o.in_ready  = 32'(a_in_ready);
      o.s_rd_en   = 32'(a_s_rd_en);
      o.addr      = 32'(a_addr);
      o.dp_load   = 32'(a_dp_load);
      o.dp_white  = 32'(a_dp_white);
      o.dp_step   = 32'(a_dp_step);
      o.ridx      = 32'(a_ridx);
      o.out_valid = 32'(a_out_valid);
      o.dp_mode   = 32'(a_dp_mode);
    end else begin
      o.in_ready  = 32'(b_in_ready);
      o.s_rd_en   = 32'(b_s_rd_en);
      o.addr      = 32'(b_addr);
      o.dp_load   = 32'(b_dp_load);
      o.dp_white  = 32'(b_dp_white);
      o.dp_step   = 32'(b_dp_step);
      o.ridx      = 32'(b_ridx);
      o.out_valid = 32'(b_out_valid);
      o.dp_mode   = 32'(b_dp_mode);
    end
    return o;
  endfunction

  // Advance the model across the coming clock edge using the current inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i] = 1'b0;
      end else if (!busy[i]) begin
        if (in_valid) begin
          busy[i] = 1'b1;
          off[i]  = 1;
          mode[i] = cur_mode();
        end
      end else if (off[i] >= rv[i] + 2) begin
        if (out_ready) busy[i] = 1'b0;
      end else begin
        off[i]++;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    exp_t o;
    string nm;
    @(negedge clk1);
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "a" : "b";
      e = model_out(i);
      o = obs(i);
      chk({nm, ".in_ready"},  o.in_ready,  e.in_ready);
      chk({nm, ".s_rd_en"},   o.s_rd_en,   e.s_rd_en);
      chk({nm, ".S_address"}, o.addr,      e.addr);
      chk({nm, ".dp_load"},   o.dp_load,   e.dp_load);
      chk({nm, ".dp_white"},  o.dp_white,  e.dp_white);
      chk({nm, ".dp_step"},   o.dp_step,   e.dp_step);
      chk({nm, ".round_idx"}, o.ridx,      e.ridx);
      chk({nm, ".out_valid"}, o.out_valid, e.out_valid);
      if (e.mode_ck) chk({nm, ".dp_mode"}, o.dp_mode, e.dp_mode);
      if (o.dp_load != 0) lat_acc[i] = cyc;
      if (o.out_valid != 0 && !ov_prev[i]) chk({nm, ".latency"}, cyc - lat_acc[i], rv[i] + 2);
      ov_prev[i] = (o.out_valid != 0);
      if (o.out_valid != 0) ov_cnt[i]++;
    end
    if (a_dp_load) begin
      if (gap_ck && last_acc >= 0) chk("a.acc_gap", cyc - last_acc, RA + 3);
      last_acc = cyc;
    end
    model_edge();
    @(posedge clk1);
    #1;
    cyc++;
  endtask

  task automatic run_block(input bit m);
    in_valid = 1'b1;
    in_mode  = m;
    tick();
    in_valid = 1'b0;
    repeat (RA + 5) tick();
  endtask

  initial begin
    rv[0] = RA;
    rv[1] = RB;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0; off[i] = 0; mode[i] = 1'b0;
      lat_acc[i] = 0; ov_prev[i] = 1'b0; ov_cnt[i] = 0;
    end

    // Power-on reset, then idle.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single encrypt block, consumer always ready.
    run_block(1'b0);
`ifdef RC5_DECRYPT_EN
    // Single decrypt block.
    run_block(1'b1);
`endif

    // Consumer stalls: out_ready low for cycles 0..18 after accept.
    out_ready = 1'b0;
    ov_cnt[0] = 0;
    ov_cnt[1] = 0;
    in_valid = 1'b1; in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (18) tick();
    out_ready = 1'b1;
    repeat (4) tick();
    chk("a.ov_held", ov_cnt[0], 6);
    chk("b.ov_held", ov_cnt[1], 17);

    // Reset in the middle of a run, then a clean block.
    in_valid = 1'b1; in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_block(1'b0);

    // Back-to-back offers with in_mode toggling while blocks are in flight.
    gap_ck = 1'b1;
    last_acc = -1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4 * (RA + 3) + 2; n++) begin
      in_mode = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    gap_ck = 1'b0;
    repeat (RA + 5) tick();

    // Random traffic with occasional resets and consumer stalls.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      in_valid  = 1'($urandom);
      in_mode   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (RA + 5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
